apb_uart_fifo: RTL and testbench
================================

Name: apb_uart_fifo

Overview:
APB3 UART peripheral with independent, parametrised TX and RX FIFOs, a 16x-oversampled receiver and a transmitter. Status, error flags and enables are exposed through a 4-register map. It is the successor to the single-FIFO, TX-only APB UART. It sits on the APB bus alongside the other peripherals, with tx/rx going to the board pins.

Parameters:
CLK_HZ, 100_000_000, PCLK frequency in Hz.
BAUD, 9600, line rate. Tick divisor is CLK_HZ/(BAUD*16), minimum 1.
TX_DEPTH, 4, TX FIFO entries. Power of 2, 2..256.
RX_DEPTH, 4, RX FIFO entries. Power of 2, 2..256.

Ports:
PCLK  in  1  clock
PRESET  in  1  reset, asynchronous, active-high
PADDR  in  4  byte address; only [3:2] decoded
PWDATA  in  32  write data
PWRITE  in  1  1 = write
PENABLE  in  1  APB access phase
PSEL  in  1  slave select
PRDATA  out  32  read data, registered
PREADY  out  1  transfer complete, registered
tx  out  1  serial out, idle high
rx  in  1  serial in, asynchronous to PCLK
irq  out  1  level interrupt

Behaviour:
- Reset values (PRESET async, active-high; clock PCLK):
  - PRDATA=0, PREADY=0, tx=1, irq=0.
  - Both FIFOs empty, all sticky flags 0, CTRL=0.
- APB handshake:
  - One wait state. PREADY<=1 in the cycle after the first PSEL&PENABLE&!PREADY; otherwise PREADY<=0.
  - All side effects (push, pop, flag clear) and the PRDATA update happen exactly once, on that first access cycle.
- Register map:
  - 0x0 STATUS, RO:
    - b0 tx_empty, b1 tx_full, b2 rx_empty, b3 rx_full
    - b4 overrun (sticky), b5 frame_err (sticky), b6 tx_busy, b7 parity_err (sticky; 0 without macro)
  - 0x4 TXDATA, WO: PWDATA[7:0] pushed to TX FIFO. Dropped silently when the FIFO is full. Reads return 0.
  - 0x8 RXDATA, RO: returns {24'b0, head} and pops. Returns 0 with no pop when empty.
  - 0xC CTRL, RW:
    - b0 tx_en, b1 rx_en, b2 irq_rx_en, b3 irq_tx_en
    - Writing 1 to b4 clears all sticky flags. b4 is self-clearing and reads 0.
- FIFOs:
  - Synchronous, pointer-based. Pointers are one bit wider than log2(DEPTH); wrap-around is handled by the MSB compare.
  - Simultaneous push and pop on a full FIFO: both succeed and count is unchanged.
  - Simultaneous push and pop on an empty FIFO: the push succeeds and the pop is ignored.
- Tick generator: free-running divisor counter producing a 1-cycle tick pulse.
- TX FSM, states IDLE, START, DATA, STOP (each bit lasts 16 ticks):
  - In IDLE, if tx_en and TX FIFO not empty: pop into the shift register in the same cycle and go to START.
  - Frame: start 0, 8 data bits LSB first, (parity), stop 1. STOP returns to IDLE.
  - Clearing tx_en mid-frame finishes the current frame, then holds in IDLE.
- RX path:
  - rx passes through a 2-FF synchroniser.
  - RX FSM states: IDLE, START, DATA, (PARITY), STOP.
  - Falling edge in IDLE with rx_en=1: count 8 ticks to mid-bit.
  - If rx is high at mid-bit, treat it as a glitch and return to IDLE.
  - Then sample every 16 ticks at bit centre.
  - Stop sample 0: set frame_err, discard the byte.
  - Good byte with RX FIFO full: set overrun, discard the byte, FIFO contents unchanged.
  - Good byte otherwise: push.
- irq = (irq_rx_en & !rx_empty) | (irq_tx_en & tx_empty & !tx_busy) | overrun | frame_err | parity_err.
- PRESET mid-frame: tx goes to 1 immediately, and a partial RX byte is lost.

Optional Feature:
UART_PARITY_EN
- Defined:
  - CTRL b5 parity_en, b6 odd (0 = even parity).
  - When parity_en=1, a parity bit is inserted between data and stop on TX, and checked on RX.
  - On RX mismatch: set parity_err, discard the byte.
- Undefined:
  - No parity logic. CTRL b5/b6 read 0 and STATUS b7 reads 0.

Test Plan (CLK_HZ=3_200_000, BAUD=100_000 → tick every 2 PCLK, bit = 32 PCLK):
1. Reset, read 0x0 → PRDATA=0x05 (tx_empty, rx_empty); tx=1; PREADY high for exactly 1 cycle per transfer.
2. CTRL=0x1, write 0x4=0xA5 → tx shows start bit, then 1,0,1,0,0,1,0,1, then stop; each bit 32 PCLK; STATUS b6 high during the frame, 0x05 after.
3. CTRL=0x0, write 0x4 five times (0x11..0x55) with TX_DEPTH=4 → STATUS b1=1. Set CTRL=0x1 → tx emits 0x11,0x22,0x33,0x44 only.
4. rx_en=1, drive frames 0x3C,0x81,0x7E,0x00,0xFF (RX_DEPTH=4) → STATUS b3=1, b4=1. Reads of 0x8 return 0x3C,0x81,0x7E,0x00, then 0 with rx_empty=1.
5. Drive a frame with stop bit 0 → frame_err=1, irq=1, no push. Write CTRL b4=1 → flags clear, irq=0. A 4-PCLK low glitch on rx → no byte, no flag.
6. With UART_PARITY_EN, CTRL=0x23: TX 0x07 → parity bit 1 (even). RX 0x07 with parity bit 0 → parity_err=1, byte dropped.

Source files
------------

// File: rtl/apb_uart_fifo.sv
// APB3 UART with independent TX/RX FIFOs, a 16x-oversampled receiver and a transmitter.
// Define UART_PARITY_EN to add parity generation/checking (CTRL b5/b6, STATUS b7).
module apb_uart_fifo #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int DivRaw = CLK_HZ / (BAUD * 16);
  localparam int Div = (DivRaw < 1) ? 1 : DivRaw;
  localparam logic [31:0] DivLast = 32'(Div - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

  logic [6:0]  ctrl_q;
  logic        parEn, parOdd;
  logic        txEn, rxEn, irqRxEn, irqTxEn;

`ifdef UART_PARITY_EN
  localparam logic [6:0] CtrlMask = 7'h6F;
  assign parEn  = ctrl_q[5];
  assign parOdd = ctrl_q[6];
`else
  localparam logic [6:0] CtrlMask = 7'h0F;
  assign parEn  = 1'b0;
  assign parOdd = 1'b0;
`endif

  assign txEn    = ctrl_q[0];
  assign rxEn    = ctrl_q[1];
  assign irqRxEn = ctrl_q[2];
  assign irqTxEn = ctrl_q[3];

  logic [31:0] divCnt_q;
  logic        tick;
  assign tick = (divCnt_q == DivLast);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) divCnt_q <= '0;
    else        divCnt_q <= tick ? '0 : divCnt_q + 32'd1;
  end

  logic        pready_q;
  logic [31:0] prdata_q, readData;
  logic        access, wrAcc, rdAcc, ctrlWr, flagClr;
  logic [1:0]  regSel;

  // Only the first cycle of an access phase has side effects; PREADY blocks a repeat.
  assign access  = PSEL && PENABLE && !pready_q;
  assign wrAcc   = access && PWRITE;
  assign rdAcc   = access && !PWRITE;
  assign regSel  = PADDR[3:2];
  assign ctrlWr  = wrAcc && (regSel == 2'd3);
  assign flagClr = ctrlWr && PWDATA[4];

  logic       txPush, txPop, txEmpty, txFull;
  logic       rxPush, rxPop, rxEmpty, rxFull;
  logic [7:0] txHead, rxHead, rxShift_q, rxShift_d;

  assign txPush = wrAcc && (regSel == 2'd1);
  assign rxPop  = rdAcc && (regSel == 2'd2);

  apb_uart_fifo_buf #(.DEPTH(TX_DEPTH)) uTxFifo (
    .PCLK(PCLK), .PRESET(PRESET), .push_i(txPush), .pop_i(txPop), .data_i(PWDATA[7:0]),
    .head_o(txHead), .empty_o(txEmpty), .full_o(txFull)
  );

  apb_uart_fifo_buf #(.DEPTH(RX_DEPTH)) uRxFifo (
    .PCLK(PCLK), .PRESET(PRESET), .push_i(rxPush), .pop_i(rxPop), .data_i(rxShift_q),
    .head_o(rxHead), .empty_o(rxEmpty), .full_o(rxFull)
  );

  logic overrun_q, frameErr_q, parityErr_q;
  logic setOverrun, setFrame, setParity;
  logic txBusy;
  logic [7:0] status;

  assign status = {parityErr_q, txBusy, frameErr_q, overrun_q, rxFull, rxEmpty, txFull, txEmpty};

  always_comb begin
    readData = '0;
    case (regSel)
      2'd0: readData = {24'b0, status};
      2'd2: if (!rxEmpty) readData = {24'b0, rxHead};
      2'd3: readData = {25'b0, ctrl_q};
      default: readData = '0;
    endcase
  end

  // A flag raised by the receiver in the same cycle as a clear survives.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      ctrl_q      <= '0;
      overrun_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      pready_q <= access;
      if (rdAcc)  prdata_q <= readData;
      if (ctrlWr) ctrl_q <= PWDATA[6:0] & CtrlMask;
      if (flagClr) begin
        overrun_q   <= 1'b0;
        frameErr_q  <= 1'b0;
        parityErr_q <= 1'b0;
      end
      if (setOverrun) overrun_q   <= 1'b1;
      if (setFrame)   frameErr_q  <= 1'b1;
      if (setParity)  parityErr_q <= 1'b1;
    end
  end

  txState_t   txState_q, txState_d;
  logic [3:0] txTick_q, txTick_d;
  logic [2:0] txBit_q, txBit_d;
  logic [7:0] txShift_q, txShift_d;
  logic       txPar_q, txPar_d, tx_q, tx_d;

  assign txBusy = (txState_q != TX_IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      txState_q <= TX_IDLE;
      txTick_q  <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txTick_q  <= txTick_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txPar_q   <= txPar_d;
      tx_q      <= tx_d;
    end
  end

  // tx_d follows the next state so the pin is a flop output aligned with the FSM.
  always_comb begin
    txState_d = txState_q;
    txTick_d  = txTick_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    txPop     = 1'b0;
    case (txState_q)
      TX_IDLE: if (txEn && !txEmpty) begin
        txPop     = 1'b1;
        txShift_d = txHead;
        txPar_d   = (^txHead) ^ parOdd;
        txTick_d  = '0;
        txState_d = TX_START;
      end
      TX_START, TX_DATA, TX_PARITY, TX_STOP: if (tick) begin
        txTick_d = txTick_q + 4'd1;
        if (txTick_q == 4'd15) begin
          case (txState_q)
            TX_START: begin
              txBit_d   = '0;
              txState_d = TX_DATA;
            end
            TX_DATA: begin
              txShift_d = {1'b0, txShift_q[7:1]};
              if (txBit_q == 3'd7) txState_d = parEn ? TX_PARITY : TX_STOP;
              else                 txBit_d   = txBit_q + 3'd1;
            end
            TX_PARITY: txState_d = TX_STOP;
            default:   txState_d = TX_IDLE;
          endcase
        end
      end
      default: txState_d = TX_IDLE;
    endcase
    case (txState_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = txShift_d[0];
      TX_PARITY: tx_d = txPar_d;
      default:   tx_d = 1'b1;
    endcase
  end

  logic       rxMeta_q, rxSync_q, rxPrev_q;
  rxState_t   rxState_q, rxState_d;
  logic [3:0] rxTick_q, rxTick_d;
  logic [2:0] rxBit_q, rxBit_d;
  logic       rxParBad_q, rxParBad_d;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rxMeta_q   <= 1'b1;
      rxSync_q   <= 1'b1;
      rxPrev_q   <= 1'b1;
      rxState_q  <= RX_IDLE;
      rxTick_q   <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      rxParBad_q <= 1'b0;
    end else begin
      rxMeta_q   <= rx;
      rxSync_q   <= rxMeta_q;
      rxPrev_q   <= rxSync_q;
      rxState_q  <= rxState_d;
      rxTick_q   <= rxTick_d;
      rxBit_q    <= rxBit_d;
      rxShift_q  <= rxShift_d;
      rxParBad_q <= rxParBad_d;
    end
  end

  // START waits half a bit to land on bit centres; a high line there means a glitch.
  always_comb begin
    rxState_d  = rxState_q;
    rxTick_d   = rxTick_q;
    rxBit_d    = rxBit_q;
    rxShift_d  = rxShift_q;
    rxParBad_d = rxParBad_q;
    rxPush     = 1'b0;
    setOverrun = 1'b0;
    setFrame   = 1'b0;
    setParity  = 1'b0;
    case (rxState_q)
      RX_IDLE: if (rxEn && rxPrev_q && !rxSync_q) begin
        rxTick_d   = '0;
        rxParBad_d = 1'b0;
        rxState_d  = RX_START;
      end
      RX_START: if (tick) begin
        rxTick_d = rxTick_q + 4'd1;
        if (rxTick_q == 4'd7) begin
          rxTick_d  = '0;
          rxBit_d   = '0;
          rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        rxTick_d = rxTick_q + 4'd1;
        if (rxTick_q == 4'd15) begin
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          if (rxBit_q == 3'd7) rxState_d = parEn ? RX_PARITY : RX_STOP;
          else                 rxBit_d   = rxBit_q + 3'd1;
        end
      end
      RX_PARITY: if (tick) begin
        rxTick_d = rxTick_q + 4'd1;
        if (rxTick_q == 4'd15) begin
          rxParBad_d = (rxSync_q != ((^rxShift_q) ^ parOdd));
          rxState_d  = RX_STOP;
        end
      end
      RX_STOP: if (tick) begin
        rxTick_d = rxTick_q + 4'd1;
        if (rxTick_q == 4'd15) begin
          rxState_d = RX_IDLE;
          if (!rxSync_q)       setFrame   = 1'b1;
          else if (rxParBad_q) setParity  = 1'b1;
          else if (rxFull)     setOverrun = 1'b1;
          else                 rxPush     = 1'b1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign tx     = tx_q;
  assign irq    = (irqRxEn && !rxEmpty) || (irqTxEn && txEmpty && !txBusy) ||
                  overrun_q || frameErr_q || parityErr_q;

  logic unusedBits;
  assign unusedBits = ^{PADDR[1:0], PWDATA[31:7]};
endmodule

// Byte FIFO; pointers carry one extra bit so full and empty differ only in the MSB.
module apb_uart_fifo_buf #(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wPtr_q, rPtr_q;
  logic        doPush, doPop;

  assign empty_o = (wPtr_q == rPtr_q);
  assign full_o  = (wPtr_q[AW] != rPtr_q[AW]) && (wPtr_q[AW-1:0] == rPtr_q[AW-1:0]);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign head_o  = mem_q[rPtr_q[AW-1:0]];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wPtr_q <= '0;
      rPtr_q <= '0;
    end else begin
      if (doPush) wPtr_q <= wPtr_q + PtrOne;
      if (doPop)  rPtr_q <= rPtr_q + PtrOne;
    end
  end

  always_ff @(posedge PCLK) begin
    if (doPush) mem_q[wPtr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Bench for apb_uart_fifo: directed and random APB/serial traffic checked against
// a queue model of both FIFOs and the sticky flags.
module tb_apb_uart_fifo;
  localparam int TxDepth   = 4;
  localparam int RxDepth   = 4;
  localparam int BitCycles = 32;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PENABLE, PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx, rx, irq;

  always #5 PCLK = ~PCLK;

  apb_uart_fifo #(
    .CLK_HZ(3_200_000), .BAUD(100_000), .TX_DEPTH(TxDepth), .RX_DEPTH(RxDepth)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
    .tx(tx), .rx(rx), .irq(irq)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] txExp[$];
  logic [7:0] rxExp[$];
  logic expOverrun, expFrame, expParity;

  function automatic logic [31:0] expStatus(input logic busy);
    return {24'b0, expParity, busy, expFrame, expOverrun, rxExp.size() == RxDepth,
            rxExp.size() == 0, txExp.size() == TxDepth, txExp.size() == 0};
  endfunction

  // Receiver rules: bad stop wins, then bad parity, then overrun, else the byte is queued.
  function automatic void modelRx(input logic [7:0] b, input logic stopOk, input logic parOk);
    if (!stopOk)                    expFrame = 1'b1;
    else if (!parOk)                expParity = 1'b1;
    else if (rxExp.size() == RxDepth) expOverrun = 1'b1;
    else                            rxExp.push_back(b);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apbWrite(input logic [3:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    checkOutput("pready_wr", PREADY, 1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("pready_drop_wr", PREADY, 0);
  endtask

  task automatic apbRead(input logic [3:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    checkOutput("pready_rd", PREADY, 1);
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("pready_drop_rd", PREADY, 0);
  endtask

  task automatic holdBit();
    repeat (BitCycles) @(posedge PCLK);
    #1;
  endtask

  // Drives one serial frame on rx.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               input bit withPar, input logic parBit);
    @(posedge PCLK); #1;
    rx = 1'b0; holdBit();
    for (int i = 0; i < 8; i++) begin rx = b[i]; holdBit(); end
    if (withPar) begin rx = parBit; holdBit(); end
    rx = stopBit; holdBit();
    rx = 1'b1;
    repeat (BitCycles / 2) @(posedge PCLK);
    #1;
  endtask

  task automatic waitTxStart(input int limit, output bit found);
    int n;
    n = 0;
    @(negedge PCLK);
    while (tx !== 1'b0 && n < limit) begin @(negedge PCLK); n++; end
    found = (tx === 1'b0);
  endtask

  // Samples each bit of a tx frame at its centre.
  task automatic captureTx(input bit withPar, output logic [7:0] data, output logic startBit,
                           output logic parBit, output logic stopBit, output bit found);
    data = '0; startBit = 1'b1; parBit = 1'b0; stopBit = 1'b0;
    waitTxStart(2000, found);
    if (!found) return;
    repeat (BitCycles / 2) @(negedge PCLK);
    startBit = tx;
    for (int i = 0; i < 8; i++) begin repeat (BitCycles) @(negedge PCLK); data[i] = tx; end
    if (withPar) begin repeat (BitCycles) @(negedge PCLK); parBit = tx; end
    repeat (BitCycles) @(negedge PCLK);
    stopBit = tx;
  endtask

  task automatic drainTx();
    logic [7:0] d, e;
    logic s0, p, s1;
    bit f;
    while (txExp.size() > 0) begin
      e = txExp.pop_front();
      captureTx(1'b0, d, s0, p, s1, f);
      checkOutput("tx_frame_seen", f, 1);
      checkOutput("tx_start_bit", s0, 0);
      checkOutput("tx_data", d, e);
      checkOutput("tx_stop_bit", s1, 1);
    end
    waitTxStart(400, f);
    checkOutput("tx_no_extra_frame", f, 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  rxList [5];
    logic        st, pb, sb;
    bit          found;
    int          n;

    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; rx = 1'b1;
    PRESET = 1'b1;
    expOverrun = 1'b0; expFrame = 1'b0; expParity = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_pready", PREADY, 0);
    checkOutput("rst_prdata", PRDATA, 0);
    PRESET = 1'b0;

    apbRead(4'h0, rd); checkOutput("status_reset", rd, 32'h05);
    apbRead(4'h4, rd); checkOutput("txdata_reads_zero", rd, 0);
    apbRead(4'hC, rd); checkOutput("ctrl_reset", rd, 0);
    apbRead(4'h8, rd); checkOutput("rxdata_empty_zero", rd, 0);

    // Single byte with tx enabled; STATUS sampled mid-frame shows busy.
    apbWrite(4'hC, 32'h1);
    apbWrite(4'h4, 32'hA5);
    fork
      captureTx(1'b0, b, st, pb, sb, found);
      begin
        repeat (100) @(posedge PCLK);
        apbRead(4'h0, rd);
        checkOutput("status_busy", rd, expStatus(1'b1));
      end
    join
    checkOutput("a5_seen", found, 1);
    checkOutput("a5_start", st, 0);
    checkOutput("a5_data", b, 8'hA5);
    checkOutput("a5_stop", sb, 1);
    repeat (20) @(posedge PCLK);
    apbRead(4'h0, rd); checkOutput("status_after_tx", rd, expStatus(1'b0));

    // Overfill with tx disabled: the fifth byte is dropped.
    apbWrite(4'hC, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i * 17);
      apbWrite(4'h4, {24'b0, b});
      if (txExp.size() < TxDepth) txExp.push_back(b);
    end
    apbRead(4'h0, rd); checkOutput("status_tx_full", rd, expStatus(1'b0));
    apbWrite(4'hC, 32'h1);
    drainTx();

    apbWrite(4'hC, 32'h0);
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      apbWrite(4'h4, {24'b0, b});
      if (txExp.size() < TxDepth) txExp.push_back(b);
    end
    apbRead(4'h0, rd); checkOutput("status_tx_rand", rd, expStatus(1'b0));
    apbWrite(4'hC, 32'h1);
    drainTx();
    apbWrite(4'hC, 32'h0);

    // Receive five frames into a four-entry FIFO.
    apbWrite(4'hC, 32'h2);
    rxList = '{8'h3C, 8'h81, 8'h7E, 8'h00, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(rxList[i], 1'b1, 1'b0, 1'b0);
      modelRx(rxList[i], 1'b1, 1'b1);
    end
    apbRead(4'h0, rd); checkOutput("status_rx_overrun", rd, expStatus(1'b0));
    checkOutput("irq_overrun", irq, 1);
    for (int i = 0; i < RxDepth; i++) begin
      apbRead(4'h8, rd);
      checkOutput("rx_read", rd, {24'b0, rxExp.pop_front()});
    end
    apbRead(4'h8, rd); checkOutput("rx_read_empty", rd, 0);
    apbRead(4'h0, rd); checkOutput("status_rx_drained", rd, expStatus(1'b0));
    apbWrite(4'hC, 32'h12);
    expOverrun = 1'b0;
    apbRead(4'hC, rd); checkOutput("ctrl_clear_bit_reads0", rd, 32'h2);
    checkOutput("irq_cleared", irq, 0);

    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      applyStimulus(b, 1'b1, 1'b0, 1'b0);
      modelRx(b, 1'b1, 1'b1);
    end
    apbRead(4'h0, rd); checkOutput("status_rx_rand", rd, expStatus(1'b0));
    while (rxExp.size() > 0) begin
      apbRead(4'h8, rd);
      checkOutput("rx_read_rand", rd, {24'b0, rxExp.pop_front()});
    end

    // Framing error, flag clear, then a short glitch that must be ignored.
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);
    modelRx(8'h5A, 1'b0, 1'b1);
    apbRead(4'h0, rd); checkOutput("status_frame_err", rd, expStatus(1'b0));
    checkOutput("irq_frame_err", irq, 1);
    apbWrite(4'hC, 32'h12);
    expFrame = 1'b0;
    checkOutput("irq_after_clear", irq, 0);
    @(posedge PCLK); #1;
    rx = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    rx = 1'b1;
    repeat (300) @(posedge PCLK);
    apbRead(4'h0, rd); checkOutput("status_after_glitch", rd, expStatus(1'b0));
    checkOutput("irq_after_glitch", irq, 0);

    apbWrite(4'hC, 32'hA);
    checkOutput("irq_tx_idle", irq, 1);
    apbWrite(4'hC, 32'h6);
    checkOutput("irq_rx_empty", irq, 0);
    b = 8'($urandom);
    applyStimulus(b, 1'b1, 1'b0, 1'b0);
    modelRx(b, 1'b1, 1'b1);
    checkOutput("irq_rx_data", irq, 1);
    apbRead(4'h8, rd); checkOutput("rx_read_irq", rd, {24'b0, rxExp.pop_front()});
    checkOutput("irq_rx_drained", irq, 0);

`ifdef UART_PARITY_EN
    apbWrite(4'hC, 32'h23);
    apbWrite(4'h4, 32'h07);
    captureTx(1'b1, b, st, pb, sb, found);
    checkOutput("par_tx_data", b, 8'h07);
    checkOutput("par_tx_even_bit", pb, 1);
    checkOutput("par_tx_stop", sb, 1);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
    modelRx(8'h07, 1'b1, 1'b0);
    apbRead(4'h0, rd); checkOutput("status_parity_err", rd, expStatus(1'b0));
    checkOutput("irq_parity_err", irq, 1);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    modelRx(8'h07, 1'b1, 1'b1);
    apbRead(4'h8, rd); checkOutput("par_rx_good", rd, {24'b0, rxExp.pop_front()});
    apbWrite(4'hC, 32'h33);
    expParity = 1'b0;
    apbRead(4'hC, rd); checkOutput("ctrl_parity_readback", rd, 32'h23);
    apbWrite(4'hC, 32'h63);
    b = 8'($urandom);
    apbWrite(4'h4, {24'b0, b});
    captureTx(1'b1, rd[7:0], st, pb, sb, found);
    checkOutput("par_tx_odd_data", rd[7:0], b);
    checkOutput("par_tx_odd_bit", pb, ~(^b));
    repeat (20) @(posedge PCLK);
`endif

    // Reset in the middle of a tx frame and a partial rx frame.
    apbWrite(4'hC, 32'h3);
    rx = 1'b0;
    apbWrite(4'h4, 32'h00);
    waitTxStart(200, found);
    checkOutput("rst_mid_frame_started", found, 1);
    repeat (48) @(negedge PCLK);
    checkOutput("tx_low_mid_frame", tx, 0);
    PRESET = 1'b1;
    #1;
    checkOutput("tx_async_reset", tx, 1);
    txExp.delete(); rxExp.delete();
    expOverrun = 1'b0; expFrame = 1'b0; expParity = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    rx = 1'b1;
    repeat (400) @(posedge PCLK);
    apbRead(4'h0, rd); checkOutput("status_after_reset", rd, expStatus(1'b0));
    apbRead(4'hC, rd); checkOutput("ctrl_after_reset", rd, 0);
    checkOutput("tx_idle_after_reset", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
